// File: rtl/fifo_bank_ctrl.sv
// Control plane for a bank of push/pop FIFOs: occupancy tracking, status flags,
// bank sequencing, round-robin pop arbitration onto one port and source back-pressure.
module fifo_bank_ctrl #(
    parameter int DATA_WIDTH = 10,
    parameter int ADDR_WIDTH = 3,
    parameter int NUM_FIFOS  = 4
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_init,
    input  logic [ADDR_WIDTH:0]          i_thr_hi_in,
    input  logic [ADDR_WIDTH:0]          i_thr_lo_in,
    input  logic [NUM_FIFOS-1:0]         i_push_in,
    input  logic                         i_pop_req,
    output logic [NUM_FIFOS-1:0]         o_push_out,
    output logic [NUM_FIFOS-1:0]         o_pop_out,
    output logic [$clog2(NUM_FIFOS)-1:0] o_sel_out,
    output logic                         o_valid_out,
    output logic [NUM_FIFOS-1:0]         o_empty,
    output logic [NUM_FIFOS-1:0]         o_full,
    output logic [NUM_FIFOS-1:0]         o_almost_full,
    output logic [NUM_FIFOS-1:0]         o_almost_empty,
    output logic                         o_pause_out,
    output logic [2:0]                   o_state_out,
    output logic                         o_idle_out,
    output logic                         o_error_out
);

    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam int SEL_W = $clog2(NUM_FIFOS);
    localparam logic [CNT_W-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    // The arbiter relies on natural wrap of the pointer, so the bank size must be a power of two.
    if (DATA_WIDTH < 1 || ADDR_WIDTH < 1 || NUM_FIFOS < 2 || NUM_FIFOS > 8 ||
        (NUM_FIFOS & (NUM_FIFOS - 1)) != 0) begin : g_param_check
        $error("fifo_bank_ctrl: unsupported parameter set");
    end

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [CNT_W-1:0]     r_thr_hi;
    logic [CNT_W-1:0]     r_thr_lo;
    logic [SEL_W-1:0]     r_rr_ptr;
    logic [SEL_W-1:0]     r_sel;
    logic                 r_valid;

    logic                 w_run;
    logic                 w_pop_en;
    logic                 w_thr_ok;
    logic                 w_overflow;
    logic                 w_grant_vld;
    logic [SEL_W-1:0]     w_grant_idx;
    logic [NUM_FIFOS-1:0] w_empty;
    logic [NUM_FIFOS-1:0] w_full;

    assign w_thr_ok   = (i_thr_lo_in < i_thr_hi_in) && (i_thr_hi_in <= DEPTH);
    assign w_overflow = w_run && (|(i_push_in & w_full));
    assign o_push_out = w_run ? (i_push_in & ~w_full) : '0;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_FIFOS; gi++) begin : g_fifo
            logic [CNT_W-1:0] r_cnt;

            always_ff @(posedge i_clk or negedge i_reset) begin
                if (!i_reset) begin
                    r_cnt <= '0;
                end else if (r_state == ST_INIT) begin
                    r_cnt <= '0;
                end else if (o_push_out[gi] && !o_pop_out[gi]) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end else if (!o_push_out[gi] && o_pop_out[gi]) begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end
            end

            assign w_empty[gi]        = (r_cnt == '0);
            assign w_full[gi]         = (r_cnt == DEPTH);
            assign o_almost_full[gi]  = (r_cnt >= r_thr_hi);
            assign o_almost_empty[gi] = (r_cnt <= r_thr_lo);
        end
    endgenerate

    assign o_empty     = w_empty;
    assign o_full      = w_full;
    assign o_pause_out = (|o_almost_full) || (r_state == ST_ERROR);
    assign o_sel_out   = r_sel;
    assign o_valid_out = r_valid;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= ST_RESET;
        end else begin
            r_state <= w_state_next;
        end
    end

    // An overflow is a hard fault and is never masked by a concurrent init request.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RESET:  w_state_next = ST_INIT;
            ST_INIT: begin
                if (!i_init) begin
                    w_state_next = w_thr_ok ? ST_IDLE : ST_ERROR;
                end
            end
            ST_IDLE: begin
                if (w_overflow)        w_state_next = ST_ERROR;
                else if (i_init)       w_state_next = ST_INIT;
                else if (|i_push_in)   w_state_next = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (w_overflow)                        w_state_next = ST_ERROR;
                else if (i_init)                       w_state_next = ST_INIT;
                else if ((&w_empty) && !(|i_push_in))  w_state_next = ST_IDLE;
            end
            ST_ERROR:  w_state_next = ST_ERROR;
            default:   w_state_next = ST_ERROR;
        endcase
    end

    always_comb begin
        o_state_out = r_state;
        o_idle_out  = (r_state == ST_IDLE);
        o_error_out = (r_state == ST_ERROR);
        w_run       = (r_state == ST_IDLE) || (r_state == ST_ACTIVE);
        w_pop_en    = (r_state == ST_ACTIVE) && i_pop_req;
    end

    // Scan from the far end so the closest non-empty FIFO to rr_ptr is written last and wins.
    always_comb begin
        logic [SEL_W-1:0] idx;
        idx         = '0;
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        o_pop_out   = '0;
        if (w_pop_en) begin
            for (int k = NUM_FIFOS - 1; k >= 0; k--) begin
                idx = r_rr_ptr + SEL_W'(k);
                if (!w_empty[idx]) begin
                    w_grant_vld = 1'b1;
                    w_grant_idx = idx;
                end
            end
        end
        if (w_grant_vld) begin
            o_pop_out[w_grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_thr_hi <= CNT_W'(6);
            r_thr_lo <= CNT_W'(1);
            r_rr_ptr <= '0;
            r_sel    <= '0;
            r_valid  <= 1'b0;
        end else begin
            if (r_state == ST_INIT) begin
                r_thr_hi <= i_thr_hi_in;
                r_thr_lo <= i_thr_lo_in;
            end
            r_valid <= w_grant_vld;
            if (w_grant_vld) begin
                r_sel    <= w_grant_idx;
                r_rr_ptr <= w_grant_idx + SEL_W'(1);
            end
        end
    end

endmodule
